// File: rtl/somador_pipelinado.sv
// somador_pipelinado: carry-pipelined adder/subtractor.
// Each stage adds one CW-bit chunk using the carry registered by the
// previous stage. Partial sums and the operands travel with the valid bit.
// Optional feature: define SOMADOR_OVF_EN to add the signed-overflow output OVF.
module somador_pipelinado #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             SUB,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             out_valid,
    input  logic             out_ready
`ifdef SOMADOR_OVF_EN
    ,
    output logic             OVF
`endif
);
    localparam int CW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    // One chunk of the ripple: returns {carry, sum}.
    function automatic logic [CW:0] add_chunk(input logic [CW-1:0] x,
                                              input logic [CW-1:0] y,
                                              input logic          ci);
        return {1'b0, x} + {1'b0, y} + {{CW{1'b0}}, ci};
    endfunction

    // Replace chunk k of a partial sum with freshly computed bits.
    function automatic logic [WIDTH-1:0] put_chunk(input logic [WIDTH-1:0] s,
                                                   input logic [CW-1:0]    c,
                                                   input int               k);
        logic [WIDTH-1:0] r;
        r = s;
        r[k*CW +: CW] = c;
        return r;
    endfunction

    // Stage registers, index = stage number
    logic             vld_p [STAGES];
    logic [WIDTH-1:0] a_p   [STAGES];
    logic [WIDTH-1:0] b_p   [STAGES];
    logic [WIDTH-1:0] sum_p [STAGES];
    logic             cy_p  [STAGES];

    // Next values computed by each stage
    logic [WIDTH-1:0] a_nx  [STAGES];
    logic [WIDTH-1:0] b_nx  [STAGES];
    logic [WIDTH-1:0] s_nx  [STAGES];
    logic             c_nx  [STAGES];

    // The whole pipe moves together; it only stops when a result is stuck
    // at the output.
    logic adv;
    assign adv       = !vld_p[LAST] || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_p[LAST];
    assign S         = sum_p[LAST];
    assign Cout      = cy_p[LAST];

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            logic [WIDTH-1:0] a_src;
            logic [WIDTH-1:0] b_src;
            logic [WIDTH-1:0] s_src;
            logic             c_src;
            logic [CW:0]      r;

            if (k == 0) begin : g_first
                // ---- stage 0: subtraction becomes A + ~B + 1, Cin dropped
                assign a_src = A;
                assign b_src = SUB ? ~B : B;
                assign c_src = SUB | Cin;
                assign s_src = '0;
            end else begin : g_next
                // ---- stage k: continue from stage k-1 registers
                assign a_src = a_p[k-1];
                assign b_src = b_p[k-1];
                assign c_src = cy_p[k-1];
                assign s_src = sum_p[k-1];
            end

            assign r       = add_chunk(a_src[k*CW +: CW], b_src[k*CW +: CW], c_src);
            assign a_nx[k] = a_src;
            assign b_nx[k] = b_src;
            assign s_nx[k] = put_chunk(s_src, r[CW-1:0], k);
            assign c_nx[k] = r[CW];
        end
    endgenerate

    // Valid bits, partial sums and carries: cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_p[k] <= 1'b0;
                sum_p[k] <= '0;
                cy_p[k]  <= 1'b0;
            end
        end else if (adv) begin
            vld_p[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                vld_p[k] <= vld_p[k-1];
            end
            for (int k = 0; k < STAGES; k++) begin
                sum_p[k] <= s_nx[k];
                cy_p[k]  <= c_nx[k];
            end
        end
    end

    // Operand carry-forward: pure data, qualified by the valid bits.
    always_ff @(posedge clk) begin
        if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                a_p[k] <= a_nx[k];
                b_p[k] <= b_nx[k];
            end
        end
    end

`ifdef SOMADOR_OVF_EN
    // Signed overflow: operands of equal sign giving a result of the other sign.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            OVF <= 1'b0;
        end else if (adv) begin
            OVF <= (a_nx[LAST][WIDTH-1] == b_nx[LAST][WIDTH-1]) &&
                   (s_nx[LAST][WIDTH-1] != a_nx[LAST][WIDTH-1]);
        end
    end
`endif

endmodule

// File: tb/tb_somador_pipelinado.sv
// Directed testbench for somador_pipelinado (WIDTH=16, STAGES=4).
// Define SOMADOR_OVF_EN to also exercise the OVF output.
module tb_somador_pipelinado;
    logic        clk;
    logic        rst;
    logic [15:0] A;
    logic [15:0] B;
    logic        Cin;
    logic        SUB;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] S;
    logic        Cout;
    logic        out_valid;
    logic        out_ready;
`ifdef SOMADOR_OVF_EN
    logic        OVF;
`endif

    int total = 0;
    int bad   = 0;

    somador_pipelinado #(.WIDTH(16), .STAGES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .SUB       (SUB),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .S         (S),
        .Cout      (Cout),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef SOMADOR_OVF_EN
        ,
        .OVF       (OVF)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock, then settle 1ns past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] b,
                         input logic c, input logic sub, input logic v);
        A = a; B = b; Cin = c; SUB = sub; in_valid = v;
    endtask

    // Single operation through an empty pipe: result after exactly 4 edges.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic c, input logic sub,
                          input logic [15:0] exp_s, input logic exp_c);
        drive(a, b, c, sub, 1'b1);
        step();
        drive(16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        chk({tag, "_early"}, {31'b0, out_valid}, 32'd0);
        step();
        chk({tag, "_vld"}, {31'b0, out_valid}, 32'd1);
        chk({tag, "_S"}, {16'b0, S}, {16'b0, exp_s});
        chk({tag, "_C"}, {31'b0, Cout}, {31'b0, exp_c});
    endtask

    logic [15:0] st_a [4] = '{16'h1234, 16'h8000, 16'h0F0F, 16'h0100};
    logic [15:0] st_b [4] = '{16'h1111, 16'h8000, 16'h00F1, 16'h0001};
    logic        st_u [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [15:0] st_s [4] = '{16'h2345, 16'h0000, 16'h1000, 16'h00FF};
    logic        st_c [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        rst = 1'b1;
        out_ready = 1'b1;
        drive(16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        chk("rst_vld", {31'b0, out_valid}, 32'd0);
        chk("rst_S", {16'b0, S}, 32'd0);
        chk("rst_C", {31'b0, Cout}, 32'd0);
        rst = 1'b0;
        step();
        chk("rst_rdy", {31'b0, in_ready}, 32'd1);

        // Basic add with wrap, add with Cin, subtractions (Cin ignored)
        run_op("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
`ifdef SOMADOR_OVF_EN
        chk("ovf_wrap", {31'b0, OVF}, 32'd0);
`endif
        step();
        run_op("add_cin", 16'h00FF, 16'h0F00, 1'b1, 1'b0, 16'h1000, 1'b0);
        step();
        run_op("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0);
        step();
        run_op("sub_pos", 16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1);
        step();
`ifdef SOMADOR_OVF_EN
        run_op("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0);
        chk("ovf_add_f", {31'b0, OVF}, 32'd1);
        step();
        run_op("ovf_sub", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1);
        chk("ovf_sub_f", {31'b0, OVF}, 32'd1);
        step();
`endif

        // Back-to-back: 8 adds i+i, results 2,4,..,16 on consecutive cycles
        for (int c = 0; c < 12; c++) begin
            if (c < 8) drive(16'(c + 1), 16'(c + 1), 1'b0, 1'b0, 1'b1);
            else       drive(16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
            step();
            if (c >= 3 && c < 11) begin
                chk("b2b_vld", {31'b0, out_valid}, 32'd1);
                chk("b2b_S", {16'b0, S}, 32'(2 * (c - 2)));
                chk("b2b_rdy", {31'b0, in_ready}, 32'd1);
            end
        end
        chk("b2b_end", {31'b0, out_valid}, 32'd0);

        // Stall: fill the pipe, hold 5 cycles, then drain in order
        for (int j = 0; j < 4; j++) begin
            drive(st_a[j], st_b[j], 1'b0, st_u[j], 1'b1);
            step();
        end
        out_ready = 1'b0;
        drive(16'hAAAA, 16'h5555, 1'b0, 1'b0, 1'b1);
        #1;
        chk("stall_rdy", {31'b0, in_ready}, 32'd0);
        for (int j = 0; j < 5; j++) begin
            step();
            chk("stall_vld", {31'b0, out_valid}, 32'd1);
            chk("stall_S", {16'b0, S}, {16'b0, st_s[0]});
            chk("stall_C", {31'b0, Cout}, {31'b0, st_c[0]});
            chk("stall_rdy2", {31'b0, in_ready}, 32'd0);
        end
        drive(16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        for (int j = 1; j < 4; j++) begin
            step();
            chk("drain_vld", {31'b0, out_valid}, 32'd1);
            chk("drain_S", {16'b0, S}, {16'b0, st_s[j]});
            chk("drain_C", {31'b0, Cout}, {31'b0, st_c[j]});
        end
        step();
        chk("drain_end", {31'b0, out_valid}, 32'd0);

        // Reset mid-flight: one result at the output, three more in flight
        for (int j = 0; j < 4; j++) begin
            drive(16'h8000, 16'h8001, 1'b0, 1'b0, 1'b1);
            step();
        end
        drive(16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        chk("mid_vld_pre", {31'b0, out_valid}, 32'd1);
        chk("mid_S_pre", {16'b0, S}, 32'h0001);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_vld", {31'b0, out_valid}, 32'd0);
        chk("mid_S", {16'b0, S}, 32'd0);
        chk("mid_C", {31'b0, Cout}, 32'd0);
        step();
        rst = 1'b0;
        #1;
        chk("mid_rdy", {31'b0, in_ready}, 32'd1);
        for (int j = 0; j < 6; j++) begin
            step();
            chk("mid_stale", {31'b0, out_valid}, 32'd0);
        end

        // Pipe still works after the mid-flight reset
        run_op("post_rst", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/somador_pipelinado.md
SOMADOR_PIPELINADO -- requirements
Module: somador_pipelinado

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand/result width in bits.
REQ-002 SHALL have parameter STAGES, default 4: number of pipeline stages; WIDTH SHALL be a multiple of STAGES (chunk width CW = WIDTH/STAGES).
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port A, input, WIDTH: operand A.
REQ-006 SHALL have port B, input, WIDTH: operand B.
REQ-007 SHALL have port Cin, input, 1: carry-in (add mode only).
REQ-008 SHALL have port SUB, input, 1: 0 = add, 1 = subtract.
REQ-009 SHALL have port in_valid, input, 1: A/B/Cin/SUB valid this cycle.
REQ-010 SHALL have port in_ready, output, 1: block accepts an operation this cycle.
REQ-011 SHALL have port S, output, WIDTH: result.
REQ-012 SHALL have port Cout, output, 1: carry-out (add) / not-borrow (subtract).
REQ-013 SHALL have port out_valid, output, 1: S/Cout hold a result.
REQ-014 SHALL have port out_ready, input, 1: downstream accepts the result.

Function
REQ-015 Add mode SHALL produce {Cout,S} = A + B + Cin, modulo 2^(WIDTH+1).
REQ-016 Subtract mode SHALL produce {Cout,S} = A + ~B + 1; Cin ignored; Cout = 1 iff A >= B unsigned.
REQ-017 Stage k (0..STAGES-1) SHALL add chunk k (bits k*CW+CW-1 .. k*CW) using the carry registered by stage k-1; stage 0 uses Cin (add) or 1 (subtract).
REQ-018 Unprocessed operand chunks and completed sum chunks SHALL be carried forward in registers alongside each stage's valid bit.
REQ-019 Pipeline advance SHALL be adv = !out_valid | out_ready; in_ready SHALL equal adv.
REQ-020 On adv, every stage SHALL shift one position; stage 0 captures inputs when in_valid=1, else loads a bubble (valid=0).
REQ-021 On !adv, all stage registers SHALL hold; S, Cout, out_valid SHALL stay stable.
REQ-022 Latency SHALL be exactly STAGES cycles from an accepted input to out_valid=1 with no stall.
REQ-023 Throughput SHALL be one operation per cycle while out_ready=1.
REQ-024 Results SHALL emerge in acceptance order; bubbles SHALL never produce out_valid=1.
REQ-025 Inputs presented with in_ready=0 SHALL be ignored (not captured).
REQ-026 Acceptance and output transfer in the same cycle SHALL both take effect.

Reset
REQ-027 rst=1 SHALL immediately clear all stage valid bits, out_valid=0, S=0, Cout=0, independent of clk.
REQ-028 Reset mid-operation SHALL discard all in-flight operations; first cycle after release in_ready=1.

Configuration
REQ-029 Macro SOMADOR_OVF_EN defined: SHALL add output OVF (1 bit) = two's-complement signed overflow of the final result, pipelined with S, reset 0.
REQ-030 Macro SOMADOR_OVF_EN undefined: OVF port and its logic SHALL be absent; all other behaviour identical.

Verification (WIDTH=16, STAGES=4)
REQ-031 Add: A=0xFFFF, B=0x0001, Cin=0, out_ready=1 -> after 4 cycles S=0x0000, Cout=1; with OVF: OVF=0.
REQ-032 Subtract: A=0x0005, B=0x0007, SUB=1 -> S=0xFFFE, Cout=0; then A=0x0007, B=0x0005 -> S=0x0002, Cout=1.
REQ-033 Back-to-back: 8 consecutive adds i+i (i=1..8), out_ready=1 -> 8 consecutive out_valid cycles, S=2,4,..,16 in order.
REQ-034 Stall: fill pipeline, out_ready=0 for 5 cycles -> in_ready=0, S held; release -> all results delivered, none lost or duplicated.
REQ-035 Reset mid-flight: assert rst with 3 operations in flight -> out_valid=0 at once; no stale result after release.
REQ-036 OVF (macro defined): A=0x7FFF, B=0x0001 add -> S=0x8000, OVF=1; A=0x8000, B=0x0001 SUB=1 -> S=0x7FFF, OVF=1.
